// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_W         = 8;
    localparam int PROD_W       = 16;
    localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/mac_sequencer.sv
// Runs one N-pair multiply-accumulate job through an external multiplier and
// accumulator, then reports the final sum and a sticky overflow flag.
module mac_sequencer #(
    parameter int LEN_W = 8,
    parameter int OP_W  = mac_pkg::OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                cfg_signed,
    output logic                busy,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_a,
    input  logic [OP_W-1:0]     op_b,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    output logic                mul_signed,
    output logic                acc_valid,
    output logic                acc_clear,
    output logic                acc_signed,
    input  logic [2*OP_W-1:0]   acc_result,
    input  logic                acc_overflow,
    output logic                done,
    output logic [2*OP_W-1:0]   result,
    output logic                ovf,
    output logic [LEN_W-1:0]    count
);
    import mac_pkg::*;

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_hs;
    logic               w_drain_end;
    logic [LEN_W-1:0]   w_count_inc;

    logic [LEN_W-1:0]   r_len;
    logic               r_signed;
    logic               r_first;
    logic [LEN_W-1:0]   r_count;
    logic [OP_W-1:0]    r_mul_a;
    logic [OP_W-1:0]    r_mul_b;
    logic               r_acc_valid;
    logic               r_acc_clear;
    logic               r_acc_valid_d;
    logic [1:0]         r_drain_cnt;
    logic [2*OP_W-1:0]  r_result;
    logic               r_ovf;

    assign w_count_inc = r_count + LEN_W'(1);
    assign w_drain_end = (r_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_hs         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (cfg_len != '0)) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_hs = op_valid;
                if (op_valid && (w_count_inc == r_len)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len         <= '0;
            r_signed      <= 1'b0;
            r_first       <= 1'b0;
            r_count       <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_acc_valid   <= 1'b0;
            r_acc_clear   <= 1'b0;
            r_acc_valid_d <= 1'b0;
            r_drain_cnt   <= '0;
            r_result      <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_acc_valid   <= w_hs;
            r_acc_clear   <= w_hs & r_first;
            r_acc_valid_d <= r_acc_valid;
            r_drain_cnt   <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;

            if (w_hs) begin
                r_mul_a <= op_a;
                r_mul_b <= op_b;
                r_count <= w_count_inc;
                r_first <= 1'b0;
            end

            if (w_accept) begin
                r_len    <= cfg_len;
                r_signed <= cfg_signed;
                r_count  <= '0;
                r_ovf    <= 1'b0;
                r_result <= '0;
                r_first  <= 1'b1;
            end else begin
                // Overflow is only valid the cycle after an update strobe.
                if (r_acc_valid_d) begin
                    r_ovf <= r_ovf | acc_overflow;
                end
                if ((r_state == DRAIN) && w_drain_end) begin
                    r_result <= acc_result;
                end
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign op_ready   = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_signed = r_signed;
    assign acc_signed = r_signed;
    assign acc_valid  = r_acc_valid;
    assign acc_clear  = r_acc_clear;
    assign result     = r_result;
    assign ovf        = r_ovf;
    assign count      = r_count;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural multiplier/accumulator.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic        cfg_signed = 1'b0;
    logic        busy;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  op_a = 8'd0;
    logic [7:0]  op_b = 8'd0;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_signed;
    logic        acc_valid;
    logic        acc_clear;
    logic        acc_signed;
    logic [15:0] acc_result;
    logic        acc_overflow;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic [7:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    mac_sequencer #(.LEN_W(8), .OP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .cfg_signed(cfg_signed), .busy(busy), .op_valid(op_valid),
        .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .mul_a(mul_a),
        .mul_b(mul_b), .mul_signed(mul_signed), .acc_valid(acc_valid),
        .acc_clear(acc_clear), .acc_signed(acc_signed),
        .acc_result(acc_result), .acc_overflow(acc_overflow), .done(done),
        .result(result), .ovf(ovf), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural 8x8 multiplier + 16+1-bit accumulator.
    logic [15:0] m_sa, m_sb, m_prod, m_base, m_acc;
    logic [16:0] m_sum;
    logic        m_ovf, m_ovf_q;

    always_comb begin
        m_sa   = {{8{mul_a[7] & mul_signed}}, mul_a};
        m_sb   = {{8{mul_b[7] & mul_signed}}, mul_b};
        m_prod = m_sa * m_sb;
        m_base = acc_clear ? 16'd0 : m_acc;
        if (acc_signed) begin
            m_sum = {m_base[15], m_base} + {m_prod[15], m_prod};
            m_ovf = m_sum[16] ^ m_sum[15];
        end else begin
            m_sum = {1'b0, m_base} + {1'b0, m_prod};
            m_ovf = m_sum[16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc   <= 16'd0;
            m_ovf_q <= 1'b0;
        end else if (acc_valid) begin
            m_acc   <= m_sum[15:0];
            m_ovf_q <= m_ovf;
        end
    end

    assign acc_result   = m_acc;
    assign acc_overflow = m_ovf_q;

    // Cycle counter and negedge monitor; tasks compare deltas of these.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mon_nvalid = 0, mon_nclear = 0, mon_clear_bad = 0;
    int mon_ndone = 0, mon_done_cyc = 0, mon_last_hs = 0, mon_ready_bad = 0;
    int mon_nbubble = 0, mon_bubble_bad = 0, mon_sgn_bad = 0;
    bit mon_prev_bubble = 1'b0;
    bit exp_sgn = 1'b0;

    always @(negedge clk) begin
        if (acc_valid) begin
            mon_nvalid++;
            if (acc_clear) begin
                mon_nclear++;
                if (mon_nvalid != 1) mon_clear_bad++;
            end
        end
        if (op_valid && op_ready) mon_last_hs = cyc;
        if (done) begin
            mon_ndone++;
            mon_done_cyc = cyc;
            if (op_ready) mon_ready_bad++;
        end
        if (mon_prev_bubble) begin
            mon_nbubble++;
            if (acc_valid) mon_bubble_bad++;
        end
        mon_prev_bubble = op_ready && !op_valid;
        if (busy && ((mul_signed !== exp_sgn) || (acc_signed !== exp_sgn))) mon_sgn_bad++;
    end

    logic [7:0] va [16];
    logic [7:0] vb [16];
    bit         pat [16];
    int         base_valid, base_clear, base_done, base_bubble;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        base_valid  = mon_nvalid;
        base_clear  = mon_nclear;
        base_done   = mon_ndone;
        base_bubble = mon_nbubble;
    endtask

    // Drives one job: start, operand stream per valid pattern, wait for done.
    task automatic run_job(input int len, input bit sgn, input int npat, input int inj_p);
        int  idx, p, guard;
        bit  hs;
        snap();
        exp_sgn    = sgn;
        start      = 1'b1;
        cfg_len    = 8'(len);
        cfg_signed = sgn;
        tick();
        start = 1'b0;
        idx = 0; p = 0; guard = 0;
        while (idx < len && guard < 100) begin
            op_valid = (p < npat) ? pat[p] : 1'b1;
            op_a     = va[idx];
            op_b     = vb[idx];
            start    = (p == inj_p);
            @(negedge clk);
            hs = op_valid && op_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            p++;
            guard++;
        end
        op_valid = 1'b0;
        start    = 1'b0;
        guard = 0;
        while (mon_ndone == base_done && guard < 20) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, op_ready, acc_valid, acc_clear, done, ovf, mul_signed, acc_signed} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {busy, op_ready, acc_valid, acc_clear, done, ovf, mul_signed, acc_signed});
        end
        n_cmp++;
        if ({mul_a, mul_b, result, count} !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {mul_a, mul_b, result, count});
        end
        rst = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_unsigned();
        va[0] = 8'd2;  vb[0] = 8'd3;
        va[1] = 8'd4;  vb[1] = 8'd5;
        va[2] = 8'd10; vb[2] = 8'd10;
        run_job(3, 1'b0, 0, -1);
        n_cmp++;
        if (result !== 16'h007E || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL unsigned_sum: got %h ovf %b want 007e ovf 0", result, ovf);
        end
        n_cmp++;
        if (mon_ndone - base_done != 1 || mon_done_cyc - mon_last_hs != 3) begin
            n_bad++;
            $display("FAIL unsigned_done_latency: got %0d dones, latency %0d want 1, 3",
                     mon_ndone - base_done, mon_done_cyc - mon_last_hs);
        end
        n_cmp++;
        if (mon_nclear - base_clear != 1 || mon_clear_bad != 0 || mon_nvalid - base_valid != 3) begin
            n_bad++;
            $display("FAIL unsigned_clear: got clears %0d bad %0d valids %0d want 1 0 3",
                     mon_nclear - base_clear, mon_clear_bad, mon_nvalid - base_valid);
        end
        n_cmp++;
        if (count !== 8'd3 || busy !== 1'b0 || op_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL unsigned_idle: got count %0d busy %b ready %b want 3 0 0", count, busy, op_ready);
        end
        repeat (3) tick();
        n_cmp++;
        if (result !== 16'h007E) begin
            n_bad++;
            $display("FAIL unsigned_hold: got %h want 007e", result);
        end
        $display("test_unsigned: result=%h ovf=%b", result, ovf);
    endtask

    task automatic test_signed();
        va[0] = 8'hFD; vb[0] = 8'h04;
        va[1] = 8'h02; vb[1] = 8'h05;
        run_job(2, 1'b1, 0, -1);
        n_cmp++;
        if (result !== 16'hFFFE || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL signed_sum: got %h ovf %b want fffe ovf 0", result, ovf);
        end
        n_cmp++;
        if (mon_sgn_bad != 0) begin
            n_bad++;
            $display("FAIL signed_mode: got %0d bad cycles want 0", mon_sgn_bad);
        end
        $display("test_signed: result=%h ovf=%b", result, ovf);
    endtask

    task automatic test_overflow();
        va[0] = 8'd255; vb[0] = 8'd255;
        va[1] = 8'd255; vb[1] = 8'd255;
        run_job(2, 1'b0, 0, -1);
        n_cmp++;
        if (result !== 16'hFC02 || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_sum: got %h ovf %b want fc02 ovf 1", result, ovf);
        end
        $display("test_overflow: result=%h ovf=%b", result, ovf);
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 4; i++) begin
            va[i] = 8'd1;
            vb[i] = 8'd1;
        end
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        pat[4] = 1; pat[5] = 0; pat[6] = 1;
        run_job(4, 1'b0, 7, -1);
        n_cmp++;
        if (result !== 16'd4 || count !== 8'd4) begin
            n_bad++;
            $display("FAIL bubble_sum: got %0d count %0d want 4 count 4", result, count);
        end
        n_cmp++;
        if (mon_nbubble - base_bubble != 3 || mon_bubble_bad != 0) begin
            n_bad++;
            $display("FAIL bubble_valid: got bubbles %0d bad %0d want 3 0",
                     mon_nbubble - base_bubble, mon_bubble_bad);
        end
        $display("test_bubbles: result=%0d count=%0d", result, count);
    endtask

    task automatic test_zero_len();
        snap();
        start   = 1'b1;
        cfg_len = 8'd0;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || op_ready !== 1'b0 || result !== 16'd4 || count !== 8'd4) begin
            n_bad++;
            $display("FAIL zero_len: got busy %b ready %b result %0d count %0d want 0 0 4 4",
                     busy, op_ready, result, count);
        end
        $display("test_zero_len: busy=%b result=%0d", busy, result);
    endtask

    task automatic test_start_mid_run();
        va[0] = 8'd1; vb[0] = 8'd2;
        va[1] = 8'd3; vb[1] = 8'd4;
        va[2] = 8'd5; vb[2] = 8'd6;
        run_job(3, 1'b0, 0, 1);
        n_cmp++;
        if (result !== 16'd44 || count !== 8'd3 || mon_ndone - base_done != 1) begin
            n_bad++;
            $display("FAIL start_mid_run: got %0d count %0d dones %0d want 44 3 1",
                     result, count, mon_ndone - base_done);
        end
        $display("test_start_mid_run: result=%0d", result);
    endtask

    task automatic test_reset_mid_job();
        snap();
        exp_sgn    = 1'b1;
        start      = 1'b1;
        cfg_len    = 8'd5;
        cfg_signed = 1'b1;
        tick();
        start    = 1'b0;
        op_valid = 1'b1;
        op_a = 8'd7; op_b = 8'd9;
        tick();
        op_a = 8'd5; op_b = 8'd5;
        tick();
        op_valid = 1'b0;
        n_cmp++;
        if (count !== 8'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: got count %0d busy %b want 2 1", count, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, op_ready, acc_valid, acc_clear, done, ovf, mul_signed, acc_signed} !== 8'd0 ||
            {mul_a, mul_b, result, count} !== 40'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b %h want 0 0",
                     {busy, op_ready, acc_valid, acc_clear, done, ovf, mul_signed, acc_signed},
                     {mul_a, mul_b, result, count});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (mon_ndone != base_done) begin
            n_bad++;
            $display("FAIL mid_reset_done: got %0d dones want 0", mon_ndone - base_done);
        end
        va[0] = 8'd3; vb[0] = 8'd3;
        run_job(1, 1'b0, 0, -1);
        n_cmp++;
        if (result !== 16'd9 || ovf !== 1'b0 || count !== 8'd1) begin
            n_bad++;
            $display("FAIL post_reset_job: got %0d ovf %b count %0d want 9 0 1", result, ovf, count);
        end
        $display("test_reset_mid_job: result=%0d", result);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_bubbles();
        test_zero_len();
        test_start_mid_run();
        test_reset_mid_job();
        n_cmp++;
        if (mon_ready_bad != 0) begin
            n_bad++;
            $display("FAIL ready_in_done: got %0d want 0", mon_ready_bad);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequences one multiply-accumulate job of N operand pairs through the shared 8x8 multiplier and the 16+1-bit accumulator. It accepts a job command, pulls operand pairs over a valid/ready stream, and drives the accumulator's `valid`/`clear_mode`/`signed_mode`. It then reports the final 16-bit result with a sticky overflow flag. The parent instantiates it beside the multiplier and the accumulator; all three share `clk` and `rst`.

## Interface
- `LEN_W`, default 8: width of the job-length and count fields.
- `OP_W`, default 8: operand width. The product is 2*OP_W = 16 bits.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request, sampled in IDLE only.
- `cfg_len`  in  LEN_W  number of operand pairs. 0 is illegal, and the start is ignored.
- `cfg_signed`  in  1  two's-complement job. Latched at start.
- `busy`  out  1  high from an accepted start until the done cycle, inclusive.
- `op_valid`  in  1  operand pair valid.
- `op_ready`  out  1  sequencer can accept a pair.
- `op_a`, `op_b`  in  OP_W each  operands.
- `mul_a`, `mul_b`  out  OP_W each  registered multiplier inputs.
- `mul_signed`  out  1  multiplier mode; equals the latched `cfg_signed`.
- `acc_valid`  out  1  accumulator update strobe.
- `acc_clear`  out  1  accumulator `clear_mode`; high on the first op of a job.
- `acc_signed`  out  1  accumulator `signed_mode`; equals the latched `cfg_signed`.
- `acc_result`  in  16  accumulator `result_out`.
- `acc_overflow`  in  1  accumulator `overflow_out`.
- `done`  out  1  one-cycle pulse when the job completes.
- `result`  out  16  final sum. Held until the next accepted start.
- `ovf`  out  1  OR of per-op overflow over the job. Held like `result`.
- `count`  out  LEN_W  operand pairs accepted in the current or last job.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, on `start && cfg_len != 0`:
  - latch `cfg_len` and `cfg_signed`;
  - clear `count`, `ovf` and `result`;
  - set a first-op flag;
  - go to RUN.
- IDLE, on `start && cfg_len == 0`: no effect.
- `op_ready` = (state == RUN). It is combinational from registered state only, never from `op_valid`.
- Handshake is `op_valid && op_ready`. On handshake:
  - `mul_a`/`mul_b` <= `op_a`/`op_b`;
  - `acc_valid` <= 1 and `acc_clear` <= first-op flag, then clear the flag;
  - `count` += 1.
- When `count` reaches the latched length, RUN goes to DRAIN.
- No handshake in a cycle: `acc_valid` <= 0 next cycle (bubble). Bubbles never alter the sum.
- Overflow sampling:
  - `acc_overflow` is meaningful only in the cycle after an `acc_valid` cycle.
  - A registered `acc_valid_d` flag marks those cycles; `ovf` |= `acc_overflow` when `acc_valid_d` is set.
- DRAIN lasts exactly 2 cycles:
  - cycle 1: last `acc_valid` is high;
  - cycle 2: `acc_result` is final; capture `result` and the final `ovf` term.
- DRAIN then goes to DONE.
- DONE lasts one cycle: `done` = 1, `busy` = 1. Next state is IDLE. A `start` in DONE is ignored.
- `start` in RUN or DRAIN is ignored; the job is unaffected.
- `mul_a`/`mul_b` hold their last value when no handshake occurs.
- Widths:
  - `result` is `acc_result` verbatim (mod 2^16).
  - The sequencer performs no arithmetic on products.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `op_ready`, `acc_valid`, `acc_clear`, `done`, `ovf`, `mul_signed`, `acc_signed` = 0;
  - `mul_a`, `mul_b`, `result`, `count` = 0.
- Throughput is one pair per cycle with `op_valid` held high.
- Last handshake in cycle T:
  - `acc_valid` high in T+1;
  - `acc_result` final in T+2;
  - `done` and `result` visible in T+3.
- Reset mid-job:
  - the sequencer returns to IDLE immediately with no `done`;
  - the accumulator resets on the same `rst`;
  - the next job starts clean.
- `op_ready` low in DRAIN, DONE and IDLE. No operand is consumed outside RUN.

## Structure
- Package `mac_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - `OP_W` = 8 and `PROD_W` = 16 constants;
  - `DRAIN_CYCLES` = 2.
- Single module, no sub-modules. The multiplier and accumulator are instantiated by the parent and wired through the `mul_*`/`acc_*` ports.
- A `mac_core_top` integration bench wraps all three for verification.

## Test plan
- Unsigned, len 3, pairs (2,3), (4,5), (10,10), `op_valid` held high:
  - `result` = 126 = 0x007E, `ovf` = 0;
  - `done` exactly 3 cycles after the last handshake;
  - `acc_clear` only on the first op.
- Signed, len 2, pairs (0xFD,0x04) and (0x02,0x05), i.e. -12 + 10:
  - `result` = 0xFFFE, `ovf` = 0;
  - `mul_signed` = `acc_signed` = 1 throughout.
- Unsigned, len 2, pairs (255,255) twice: `result` = 0xFC02, `ovf` = 1.
- Len 4 with `op_valid` toggled 1,0,0,1,1,0,1, pairs (1,1) each:
  - `result` = 4;
  - `acc_valid` low in every bubble;
  - `count` = 4.
- `start` with `cfg_len` = 0: stays IDLE, `busy` = 0. `start` pulsed mid-RUN: ignored, and the original job completes with the correct sum.
- Assert `rst` in RUN after 2 of 5 pairs:
  - all outputs return to reset values with no `done`;
  - a following len-1 job (3,3) yields `result` = 9 (no stale sum).
